// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   DEFAULT_CLKS_PER_BIT : clocks per bit at 100 MHz / 115200 baud
//   UART_DATA_WIDTH      : data bits per frame (matches the FIFO width)
//   uart_tx_state_t      : transmit serializer FSM states
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_WIDTH      = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running bit-period counter, 0..CLKS_PER_BIT-1.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : synchronous restart of the count at 0 on the next cycle
//   tick  : high on the last cycle of each bit period (count == CLKS_PER_BIT-1)
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: drains the TX FIFO and sends each byte as an 8N1 frame,
// LSB first.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   fifo_empty  : TX FIFO empty flag (sampled only in IDLE)
//   fifo_r_data : TX FIFO read data, valid the cycle after fifo_re
//   fifo_re     : one-cycle pop pulse per byte
//   tx          : registered serial line, idles high
//   busy        : high from FETCH through STOP
//   done        : one-cycle pulse on the last cycle of the stop bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_re,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_tx_state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_shift;
    logic [BW-1:0]         bit_idx;
    logic                  tick;
    logic                  tx_nxt;

    // Clearing during LOAD puts the counter at 0 on the first START cycle,
    // so every bit period is exactly CLKS_PER_BIT long.
    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == LOAD),
        .tick (tick)
    );

    assign shreg_shift = shreg >> 1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = FETCH;
            FETCH: state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: if (tick) state_nxt = DATA;
            DATA:  if (tick && bit_idx == LAST_BIT) state_nxt = STOP;
            STOP:  if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode. tx is registered, so its next value is derived from the
    // next state (and the next shift-register LSB while in DATA).
    always_comb begin
        fifo_re = (state == FETCH);
        busy    = (state != IDLE);
        done    = (state == STOP) && tick;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = (state == DATA && tick) ? shreg_shift[0] : shreg[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // Shift register, bit index and line register
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
        end else begin
            tx <= tx_nxt;
            case (state)
                LOAD: begin
                    shreg   <= fifo_r_data;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (tick) begin
                        shreg   <= shreg_shift;
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench for uart_tx_serializer at
// CLKS_PER_BIT=4 with a behavioural TX FIFO (registered read data).
module tb_uart_tx_serializer;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       fifo_empty;
    logic [7:0] fifo_r_data;
    logic       fifo_re;
    logic       tx;
    logic       busy;
    logic       done;

    logic       push;
    logic [7:0] push_data;
    logic [7:0] q[$];
    int         fifo_cnt;

    int cyc;
    int re_cnt;
    int viol;
    int checks;
    int errors;

    logic [7:0] exp_q[$];

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_r_data(fifo_r_data),
        .fifo_re    (fifo_re),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural FIFO: pop data appears the cycle after fifo_re.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            fifo_cnt    <= 0;
            fifo_r_data <= 8'h00;
        end else begin
            if (fifo_re && fifo_cnt != 0) fifo_r_data <= q.pop_front();
            if (push) q.push_back(push_data);
            fifo_cnt <= fifo_cnt + (push ? 1 : 0) - ((fifo_re && fifo_cnt != 0) ? 1 : 0);
        end
    end
    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_re) re_cnt <= re_cnt + 1;
        if (fifo_re && fifo_empty) viol <= viol + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_data = b;
        push      = 1'b1;
        @(negedge clk);
        push      = 1'b0;
    endtask

    // Line image of one frame, one sample per clock: start, 8 data LSB first, stop.
    function automatic logic [FRAME-1:0] expand(input logic [7:0] b);
        logic [9:0]       f;
        logic [FRAME-1:0] e;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < CPB; j++)
                e[CPB*i+j] = f[i];
        return e;
    endfunction

    // Mid-bit sampler over a captured frame.
    function automatic logic [7:0] dec(input logic [FRAME-1:0] ln);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ln[CPB*(i+1) + CPB/2];
        return b;
    endfunction

    // Waits (bounded) for tx to fall, then records tx on each of the frame's
    // cycles, plus where done was seen and how many cycles it was high.
    task automatic capture(input string tag, output logic [FRAME-1:0] ln,
                           output int fall, output int done_at, output int done_n);
        int n;
        n       = 0;
        ln      = '1;
        done_at = -1;
        done_n  = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        fall = cyc;
        chk({tag, "_start_seen"}, tx, 1'b0);
        if (tx === 1'b0) begin
            for (int s = 0; s < FRAME; s++) begin
                if (s != 0) @(negedge clk);
                ln[s] = tx;
                if (done === 1'b1) begin
                    done_n++;
                    if (done_at < 0) done_at = s;
                end
            end
        end
    endtask

    initial begin
        logic [FRAME-1:0] ln;
        int fall, fa, fb, done_at, done_n, t_empty, re0, n;

        rst       = 1'b1;
        push      = 1'b0;
        push_data = 8'h00;
        cyc       = 0;
        re_cnt    = 0;
        viol      = 0;
        checks    = 0;
        errors    = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", {tx, fifo_re, busy, done}, 4'b1000);
        rst = 1'b0;

        // Idle with an empty FIFO
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_empty", {tx, fifo_re, busy, done}, 4'b1000);
        end

        // Single byte 0x55: latency, exact line image, done position
        re0 = re_cnt;
        push_byte(8'h55);
        chk("empty_fell", fifo_empty, 1'b0);
        t_empty = cyc;
        capture("b55", ln, fall, done_at, done_n);
        chk("latency_empty_to_tx", fall - t_empty, 3);
        chk("frame_55", ln, expand(8'h55));
        // done rides on the 40th (last) cycle of the frame
        chk("done_pos_55", done_at, FRAME - 1);
        chk("done_once_55", done_n, 1);
        @(negedge clk);
        chk("busy_drop_55", busy, 1'b0);
        chk("re_pulses_55", re_cnt - re0, 1);
        chk("fifo_end_empty", fifo_empty, 1'b1);

        // Back-to-back 0xA3, 0x0F
        re0 = re_cnt;
        push_byte(8'hA3);
        push_byte(8'h0F);
        capture("bA3", ln, fa, done_at, done_n);
        chk("byte_A3", dec(ln), 8'hA3);
        capture("b0F", ln, fb, done_at, done_n);
        chk("byte_0F", dec(ln), 8'h0F);
        // stop bit of the first frame starts 36 cycles after its fall
        chk("gap_high", fb - fa - (FRAME - CPB), CPB + 3);
        chk("re_pulses_2", re_cnt - re0, 2);

        // All-zero and all-one data
        push_byte(8'h00);
        push_byte(8'hFF);
        capture("b00", ln, fall, done_at, done_n);
        chk("frame_00", ln, expand(8'h00));
        chk("byte_00", dec(ln), 8'h00);
        capture("bFF", ln, fall, done_at, done_n);
        chk("frame_FF", ln, expand(8'hFF));
        chk("byte_FF", dec(ln), 8'hFF);

        // Reset in the middle of data bit 4 of 0x3C with 0x99 queued
        push_byte(8'h3C);
        push_byte(8'h99);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_frame_start", tx, 1'b0);
        repeat (CPB*5 + CPB/2) @(negedge clk);
        chk("bit4_mid_3C", tx, 1'b1);
        chk("busy_mid_frame", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_tx_high", tx, 1'b1);
        chk("rst_idle", {busy, fifo_re, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        re0 = re_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {tx, fifo_re, busy}, 3'b100);
        end
        chk("post_rst_no_pop", re_cnt - re0, 0);
        chk("post_rst_fifo_empty", fifo_empty, 1'b1);

        // 200 random bytes at random gaps
        re0 = re_cnt;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [7:0] b;
                    int gap;
                    b   = 8'($urandom_range(0, 255));
                    gap = int'($urandom_range(0, 40));
                    exp_q.push_back(b);
                    push_byte(b);
                    repeat (gap) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [FRAME-1:0] rl;
                    logic [7:0] eb;
                    int rf, rda, rdn;
                    capture("rnd", rl, rf, rda, rdn);
                    eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
                    chk("rnd_frame", rl, expand(eb));
                end
            end
        join
        repeat (5) @(negedge clk);
        chk("rnd_re_count", re_cnt - re0, 200);
        chk("re_while_empty", viol, 0);
        chk("rnd_fifo_empty", fifo_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
